// File: rtl/sdram_traffic_checker.sv
// sdram_traffic_checker: self-test traffic source for the sdram_controller 128-bit user port.
// Writes NUM_OPS seeded patterns, reads them back and reports mismatches, latencies and cycles.
module sdram_traffic_checker #(
    parameter int unsigned       DATA_W      = 128,
    parameter int unsigned       ADDR_W      = 22,
    parameter int unsigned       NUM_OPS     = 4,
    parameter int unsigned       MODE        = 0,
    parameter logic [ADDR_W-1:0] ADDR_BASE   = '0,
    parameter logic [ADDR_W-1:0] ADDR_STRIDE = 1,
    parameter logic [31:0]       SEED        = 32'hDEADBEEF,
    parameter int unsigned       GAP_CYCLES  = 1,
    parameter int unsigned       TIMEOUT     = 1024
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              istart,
    input  logic              iinit_done,
    output logic              owrite_req,
    output logic [ADDR_W-1:0] owrite_address,
    output logic [DATA_W-1:0] owrite_data,
    input  logic              iwrite_ack,
    output logic              oread_req,
    output logic [ADDR_W-1:0] oread_address,
    input  logic [DATA_W-1:0] iread_data,
    input  logic              iread_ack,
    output logic              obusy,
    output logic              odone,
    output logic              opass,
    output logic              otimeout,
    output logic [15:0]       oerr_count,
    output logic [15:0]       ofirst_err_index,
    output logic [15:0]       omax_write_latency,
    output logic [15:0]       omax_read_latency,
    output logic [31:0]       ototal_cycles
);

    localparam int unsigned LANES   = DATA_W / 32;
    localparam logic [15:0] LAST_OP = 16'(NUM_OPS - 1);

    typedef enum logic [2:0] {
        StIdle, StWaitInit, StIssueWr, StWaitWr, StIssueRd, StWaitRd, StGap, StDone
    } state_e;

    function automatic logic [DATA_W-1:0] op_data(input logic [15:0] k);
        logic [DATA_W-1:0] d;
        logic [31:0]       base;
        d    = '0;
        base = SEED + {16'h0, k} * 32'h01010101;
        for (int j = 0; j < int'(LANES); j++) d[32*j +: 32] = base + 32'(j);
        return d;
    endfunction

    function automatic logic [ADDR_W-1:0] op_addr(input logic [15:0] k);
        logic [ADDR_W-1:0] kk;
        kk = ADDR_W'(k);
        return ADDR_BASE + kk * ADDR_STRIDE;
    endfunction

    state_e            state_q, state_d;
    logic [15:0]       op_q, op_d;
    logic              pend_wr_q, pend_wr_d;
    logic [31:0]       lat_q, lat_d;
    logic [31:0]       gap_q, gap_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
    logic [15:0]       err_q, err_d, first_q, first_d;
    logic [15:0]       maxw_q, maxw_d, maxr_q, maxr_d;
    logic [31:0]       total_q, total_d;

    logic        advance, abort, nxt_wr;
    logic [15:0] nxt_op, lat_sat;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pend_wr_d = pend_wr_q;
        lat_d     = lat_q;
        gap_d     = gap_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        raddr_d   = raddr_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        first_d   = first_q;
        maxw_d    = maxw_q;
        maxr_d    = maxr_q;
        total_d   = total_q;
        advance   = 1'b0;
        abort     = 1'b0;
        nxt_wr    = 1'b0;
        nxt_op    = op_q;
        lat_sat   = (lat_q > 32'hFFFF) ? 16'hFFFF : lat_q[15:0];

        if (state_q inside {StIssueWr, StWaitWr, StIssueRd, StWaitRd, StGap} &&
            total_q != 32'hFFFF_FFFF) begin
            total_d = total_q + 32'd1;
        end

        case (state_q)
            StIdle, StDone: begin
                if (istart) begin
                    err_d   = '0;
                    first_d = '0;
                    maxw_d  = '0;
                    maxr_d  = '0;
                    total_d = '0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    tmo_d   = 1'b0;
                    busy_d  = 1'b1;
                    op_d    = '0;
                    state_d = StWaitInit;
                end
            end
            StWaitInit: begin
                if (iinit_done) begin
                    op_d    = '0;
                    state_d = StIssueWr;
                end
            end
            StIssueWr: begin
                lat_d   = 32'd1;
                state_d = StWaitWr;
            end
            StIssueRd: begin
                lat_d   = 32'd1;
                state_d = StWaitRd;
            end
            StWaitWr: begin
                if (iwrite_ack) begin
                    if (lat_sat > maxw_q) maxw_d = lat_sat;
                    if (MODE == 0) begin
                        state_d = StIssueRd;
                    end else begin
                        // Phased: after the last write, the read phase restarts at op 0.
                        advance = 1'b1;
                        nxt_wr  = (op_q != LAST_OP);
                        nxt_op  = (op_q == LAST_OP) ? 16'd0 : op_q + 16'd1;
                    end
                end else if (lat_q + 32'd1 >= TIMEOUT) begin
                    abort = 1'b1;
                end else begin
                    lat_d = lat_q + 32'd1;
                end
            end
            StWaitRd: begin
                if (iread_ack) begin
                    if (lat_sat > maxr_q) maxr_d = lat_sat;
                    if (iread_data != op_data(op_q)) begin
                        if (err_q == 16'd0) first_d = op_q;
                        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
                    end
                    if (op_q == LAST_OP) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        pass_d  = (err_d == 16'd0);
                        state_d = StDone;
                    end else begin
                        advance = 1'b1;
                        nxt_wr  = (MODE == 0);
                        nxt_op  = op_q + 16'd1;
                    end
                end else if (lat_q + 32'd1 >= TIMEOUT) begin
                    abort = 1'b1;
                end else begin
                    lat_d = lat_q + 32'd1;
                end
            end
            StGap: begin
                if (gap_q >= GAP_CYCLES) begin
                    state_d = pend_wr_q ? StIssueWr : StIssueRd;
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            tmo_d   = 1'b1;
            pass_d  = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
        end

        if (advance) begin
            op_d      = nxt_op;
            pend_wr_d = nxt_wr;
            if (GAP_CYCLES != 0) begin
                gap_d   = 32'd1;
                state_d = StGap;
            end else begin
                state_d = nxt_wr ? StIssueWr : StIssueRd;
            end
        end

        // Address/data are loaded on entry so they are valid during the request cycle.
        if (state_d == StIssueWr) begin
            waddr_d = op_addr(op_d);
            wdata_d = op_data(op_d);
        end
        if (state_d == StIssueRd) raddr_d = op_addr(op_d);
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            pend_wr_q <= 1'b0;
            lat_q     <= '0;
            gap_q     <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            raddr_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            tmo_q     <= 1'b0;
            err_q     <= '0;
            first_q   <= '0;
            maxw_q    <= '0;
            maxr_q    <= '0;
            total_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pend_wr_q <= pend_wr_d;
            lat_q     <= lat_d;
            gap_q     <= gap_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            raddr_q   <= raddr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            first_q   <= first_d;
            maxw_q    <= maxw_d;
            maxr_q    <= maxr_d;
            total_q   <= total_d;
        end
    end

    assign owrite_req         = (state_q == StIssueWr);
    assign oread_req          = (state_q == StIssueRd);
    assign owrite_address     = waddr_q;
    assign owrite_data        = wdata_q;
    assign oread_address      = raddr_q;
    assign obusy              = busy_q;
    assign odone              = done_q;
    assign opass              = pass_q;
    assign otimeout           = tmo_q;
    assign oerr_count         = err_q;
    assign ofirst_err_index   = first_q;
    assign omax_write_latency = maxw_q;
    assign omax_read_latency  = maxr_q;
    assign ototal_cycles      = total_q;

endmodule
